traffic_sensor_conditioner: RTL

- Upstream stage of the two-street traffic light controller. Turns raw vehicle-loop detector signals for street A and street B into the clean car-present inputs Sa and Sb.
- Per channel: 2-flop synchronizer, then a stability-count debouncer, then a presence FSM with a gap-out hold extension, plus a saturating vehicle-arrival counter.
- Sa/Sb connect directly to the controller's Sa/Sb inputs, in the same clock domain.

---
 rtl/traffic_sensor_conditioner.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Traffic sensor conditioner: turns raw loop-detector inputs for streets A and B into clean
// car-present flags for the light controller.
// Per channel: 2-flop synchronizer -> stability-count debouncer -> presence FSM with gap-out
// hold, plus a saturating arrival counter.
// Optional stuck-detector fault logic is compiled in when SENSOR_FAULT_EN is defined; without
// it fault_a/fault_b are tied to 0 and STUCK_CYCLES has no effect.
// Channel index 0 is street A, index 1 is street B.

module traffic_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             loop_a,
  input  logic             loop_b,
  input  logic             clr_counts,
  output logic             Sa,
  output logic             Sb,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             fault_a,
  output logic             fault_b
);

  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOcc  = 2'd1,
    StHold = 2'd2
  } state_e;

  // Synchronizer and debouncer state
  logic [1:0]     s1_q, s1_d;
  logic [1:0]     s2_q, s2_d;
  logic [1:0]     deb_q, deb_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  // Presence FSM and counters
  state_e           state_q [2];
  state_e           state_d [2];
  logic [HoldW-1:0] hold_q  [2];
  logic [HoldW-1:0] hold_d  [2];
  logic [1:0]       sx_q, sx_d;
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  // Edge strobes of the debounced level and the per-channel count enable
  logic [1:0] deb_rise;
  logic [1:0] deb_fall;
  logic [1:0] inc_ok;

`ifdef SENSOR_FAULT_EN
  localparam int unsigned StuckW    = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
  localparam logic [StuckW-1:0] StuckLast = StuckW'(STUCK_CYCLES - 1);

  logic [StuckW-1:0] stuck_q [2];
  logic [StuckW-1:0] stuck_d [2];
  logic [1:0]        fault_q, fault_d;
`else
  // Threshold only matters for the fault build; fold it into a dummy to keep lint quiet
  logic unused_stuck_cycles;
  assign unused_stuck_cycles = ^STUCK_CYCLES;
`endif

  // Synchronizer and debouncer next state
  always_comb begin
    s1_d  = {loop_b, loop_a};
    s2_d  = s1_q;
    deb_d = deb_q;
    for (int c = 0; c < 2; c++) begin
      db_cnt_d[c] = db_cnt_q[c];
      if (s2_q[c] == deb_q[c]) begin
        // Any return to the accepted level restarts qualification
        db_cnt_d[c] = '0;
      end else if (db_cnt_q[c] == DbLast) begin
        deb_d[c]    = s2_q[c];
        db_cnt_d[c] = '0;
      end else begin
        db_cnt_d[c] = db_cnt_q[c] + DbW'(1);
      end
    end
    deb_rise = deb_d & ~deb_q;
    deb_fall = deb_q & ~deb_d;
  end

  // Presence FSM, optional stuck detection and arrival counters
  always_comb begin
    inc_ok = 2'b11;
`ifdef SENSOR_FAULT_EN
    fault_d = fault_q;
`endif
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      hold_d[c]  = hold_q[c];

      unique case (state_q[c])
        StIdle: begin
          if (deb_q[c]) state_d[c] = StOcc;
        end
        StOcc: begin
          if (!deb_q[c]) begin
            state_d[c] = StHold;
            hold_d[c]  = HoldLast;
          end
        end
        StHold: begin
          if (deb_q[c]) begin
            state_d[c] = StOcc;
          end else if (hold_q[c] == '0) begin
            state_d[c] = StIdle;
          end else begin
            hold_d[c] = hold_q[c] - HoldW'(1);
          end
        end
        default: state_d[c] = StIdle;
      endcase

`ifdef SENSOR_FAULT_EN
      stuck_d[c] = stuck_q[c];
      if (!deb_q[c]) begin
        stuck_d[c] = '0;
      end else if (!fault_q[c]) begin
        stuck_d[c] = stuck_q[c] + StuckW'(1);
      end

      if (fault_q[c]) begin
        // Parked in idle until the detector releases; no hold on the way out
        state_d[c] = StIdle;
        inc_ok[c]  = 1'b0;
        if (deb_fall[c]) fault_d[c] = 1'b0;
      end else if (deb_q[c] && (stuck_q[c] == StuckLast)) begin
        fault_d[c] = 1'b1;
        state_d[c] = StIdle;
      end
`else
      if (deb_fall[c]) begin
        // Falling edge is handled by the FSM through deb_q
      end
`endif

      sx_d[c] = (state_d[c] != StIdle);

      cnt_d[c] = cnt_q[c];
      if (clr_counts) begin
        cnt_d[c] = '0;
      end else if (deb_rise[c] && inc_ok[c] && (cnt_q[c] != CntMax)) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      deb_q <= '0;
      sx_q  <= '0;
      for (int c = 0; c < 2; c++) begin
        db_cnt_q[c] <= '0;
        state_q[c]  <= StIdle;
        hold_q[c]   <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      sx_q  <= sx_d;
      for (int c = 0; c < 2; c++) begin
        db_cnt_q[c] <= db_cnt_d[c];
        state_q[c]  <= state_d[c];
        hold_q[c]   <= hold_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

`ifdef SENSOR_FAULT_EN
  // Stuck-detector registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= '0;
      for (int c = 0; c < 2; c++) begin
        stuck_q[c] <= '0;
      end
    end else begin
      fault_q <= fault_d;
      for (int c = 0; c < 2; c++) begin
        stuck_q[c] <= stuck_d[c];
      end
    end
  end

  assign fault_a = fault_q[0];
  assign fault_b = fault_q[1];
`else
  assign fault_a = 1'b0;
  assign fault_b = 1'b0;
`endif

  assign Sa      = sx_q[0];
  assign Sb      = sx_q[1];
  assign count_a = cnt_q[0];
  assign count_b = cnt_q[1];

endmodule
